mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Sequences and shares the core's single SRAM-like memory port between the datapath's instruction-fetch and data (load/store) requesters. Each requester gets a one-cycle completion pulse and a shared stall indication. The block sits between the datapath and the memory/bridge. It serializes one transaction at a time through an address phase and a data phase, with data accesses taking priority over fetch.

## Interface
- TIMEOUT, 255: max cycles a transaction may spend in ADDR+DATA before abort (only with macro).
- RD_ERR_VAL, 32'hDEAD_BEEF: rdata returned on a timed-out transaction.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_done.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch data; valid in the if_done cycle.
- if_done  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held with d_* stable until d_done.
- d_wr  in  1  1 = store, 0 = load.
- d_wstrb  in  4  byte enables for stores.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid in the d_done cycle.
- d_done  out  1  one-cycle completion pulse.
- stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done).
- mem_req  out  1  address-phase request (registered).
- mem_wr, mem_wstrb, mem_addr, mem_wdata  out  1/4/32/32  latched transaction fields (registered).
- mem_addr_ok  in  1  address accepted this cycle.
- mem_data_ok  in  1  data phase complete this cycle.
- mem_rdata  in  32  read data; valid with mem_data_ok.
- err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE, grant:
  - If d_req=1, latch d_* and set owner=D.
  - Else if if_req=1, latch if_addr with mem_wr=0 and mem_wstrb=0, and set owner=IF.
  - Either grant moves to ADDR.
  - Otherwise stay in IDLE.
- ADDR: mem_req=1 and fields stable. On mem_addr_ok, go to DATA. mem_data_ok is ignored in ADDR.
- DATA: mem_req=0. On mem_data_ok, capture mem_rdata into the owner's rdata register and go to DONE. Store data is captured too; requesters ignore it.
- DONE: assert the owner's done for exactly one cycle, then go to IDLE.
  - The owner's req is still high in this cycle and is not re-granted.
  - A request present in the following IDLE cycle is treated as new.
- Priority is fixed, data over fetch. Fetch waits while a data request is pending or being served.
- Only one transaction is outstanding. mem_addr_ok is only sampled in ADDR.
- rdata registers hold their value until the next capture.

## Timing
- Reset values: state=IDLE; mem_req=0; mem_wr=0; mem_wstrb=0; mem_addr=0; mem_wdata=0; if_done=d_done=0; if_rdata=d_rdata=0; err=0.
- Minimum latency with a zero-wait memory (addr_ok in the first ADDR cycle, data_ok in the first DATA cycle):
  - req sampled at edge 0;
  - mem_req high in cycle 1;
  - DATA in cycle 2;
  - done in cycle 3;
  - IDLE in cycle 4.
- Back-to-back accesses to one requester therefore take 4 cycles.
- Each wait cycle of addr_ok or data_ok adds one cycle.
- If d_req and if_req rise in the same cycle, data is served first. Fetch is granted in the IDLE cycle after d_done.
- Reset asserted mid-transaction forces IDLE at the next edge with mem_req=0 and no done pulse.
  - A late mem_data_ok that arrives in IDLE is ignored.
- A requester dropping req before done is illegal and not checked. The transaction completes and done pulses anyway.

## Configuration
- MEM_BUS_ARBITER_TIMEOUT_EN defined:
  - An 8-bit-min counter (width clog2(TIMEOUT+1)) clears on entry to ADDR and increments each ADDR/DATA cycle.
  - When it reaches TIMEOUT, the FSM goes to DONE with owner rdata=RD_ERR_VAL and err is set.
  - err stays set until rst.
- MEM_BUS_ARBITER_TIMEOUT_EN undefined: no counter exists, err is tied to 0, and the FSM waits indefinitely for mem_addr_ok/mem_data_ok.

## Test plan
- Fetch, zero-wait: if_req=1, if_addr=0xBFC00000, mem_rdata=0x24080001.
  - Required: mem_req high 1 cycle, then if_done 3 cycles after grant with if_rdata=0x24080001.
  - stall=1 until the done cycle.
- Store: d_req=1, d_wr=1, d_wstrb=4'b0011, d_addr=0x80000010, d_wdata=0x1234ABCD.
  - Required: mem_* carry exactly these values while mem_req=1; d_done pulses once.
- Collision: if_req and d_req both rise in the same cycle.
  - Required: data is served first; fetch is granted in the cycle after d_done; exactly one done pulse each.
- Wait states: mem_addr_ok delayed 2 cycles and mem_data_ok delayed 3 cycles.
  - Required: mem_req is held for 3 cycles with fields stable; latency is 4+5=9 cycles; done is a single cycle.
- Reset mid-DATA: assert rst for 1 cycle in DATA, then pulse mem_data_ok.
  - Required: mem_req=0, no done pulse, and all outputs at their reset values.
- With MEM_BUS_ARBITER_TIMEOUT_EN and TIMEOUT=16: never assert mem_addr_ok.
  - Required: done after the 16th ADDR cycle, rdata=0xDEADBEEF, err=1 until rst.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Serializes instruction-fetch and load/store requests onto one SRAM-like memory port (data wins).
// Optional transaction watchdog enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  parameter int unsigned TIMEOUT    = 255,
`endif
  parameter logic [31:0] RD_ERR_VAL = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t      state;
  owner_t      owner;
  logic        timeout_hit;
  logic        abort;
  logic        complete;
  logic [31:0] cap_val;

  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt;

  // Fires on the edge that would take the count to TIMEOUT.
  assign timeout_hit = ((state == ADDR) || (state == DATA)) &&
                       (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE) tmo_cnt <= '0;
      else if ((state == ADDR) || (state == DATA)) tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (abort) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    abort    = 1'b0;
    complete = 1'b0;
    cap_val  = mem_rdata;
    if ((state == DATA) && mem_data_ok) begin
      complete = 1'b1;
    end else if (timeout_hit) begin
      abort    = 1'b1;
      complete = 1'b1;
      cap_val  = RD_ERR_VAL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, including the rdata holding registers.
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (complete) begin
        state   <= DONE;
        mem_req <= 1'b0;
        if (owner == OWN_D) begin
          d_rdata <= cap_val;
          d_done  <= 1'b1;
        end else begin
          if_rdata <= cap_val;
          if_done  <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (d_req) begin
              owner     <= OWN_D;
              mem_wr    <= d_wr;
              mem_wstrb <= d_wstrb;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_req   <= 1'b1;
              state     <= ADDR;
            end else if (if_req) begin
              owner     <= OWN_IF;
              mem_wr    <= 1'b0;
              mem_wstrb <= '0;
              mem_addr  <= if_addr;
              mem_req   <= 1'b1;
              state     <= ADDR;
            end
          end
          ADDR: begin
            if (mem_addr_ok) begin
              mem_req <= 1'b0;
              state   <= DATA;
            end
          end
          DATA: ;
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
